constraint_stream_eval: RTL and testbench

CONSTRAINT_STREAM_EVAL -- requirements
Module: constraint_stream_eval

---
 rtl/constraint_stream_eval.sv | 138 +++++++++++++
 tb/tb_constraint_stream_eval.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/constraint_stream_eval.sv
// Streaming constraint evaluator: folds a per-beat (data << SHIFT)==0 test
// across a frame with ALL/ANY aggregation and holds one result per frame.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      operand beat handshake
//   in_data, in_last       operand value and frame-close flag
//   mode                   0 = ALL pass, 1 = ANY pass (latched on first beat)
//   out_valid/out_ready    result handshake
//   out_sat                aggregated constraint result
//   out_count              beats in the reported frame
//   out_ovf                frame force-closed at MAX_BEATS
//   out_fail_idx           1-based index of first failing beat, 0 if none
//                          (present only with CONSTRAINT_FAIL_IDX_EN defined)
module constraint_stream_eval #(
  parameter int WIDTH     = 10,
  parameter int SHIFT     = 2,
  parameter int MAX_BEATS = 16,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sat,
  output logic [CW-1:0]    out_count,
`ifdef CONSTRAINT_FAIL_IDX_EN
  output logic [CW-1:0]    out_fail_idx,
`endif
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] MAXC = CW'(MAX_BEATS);

  state_t state, state_nx;

  logic          acc_q;
  logic          mode_q;
  logic          ovf_q;
  logic [CW-1:0] cnt_q;

  logic          take;
  logic          first;
  logic [WIDTH-1:0] shifted;
  logic          c;
  logic [CW-1:0] cnt_nx;
  logic          close;

  // Shift truncated to WIDTH: only the low WIDTH-SHIFT bits survive.
  assign shifted = in_data << SHIFT;
  assign c       = (shifted == '0);

  assign take   = in_valid & in_ready;
  assign first  = (state == IDLE);
  assign cnt_nx = first ? CW'(1) : cnt_q + CW'(1);
  assign close  = in_last | (cnt_nx == MAXC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, ACCUM: begin
        if (take) state_nx = close ? HOLD : ACCUM;
      end
      HOLD: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE, ACCUM: in_ready  = 1'b1;
      HOLD:        out_valid = 1'b1;
      default:     in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= 1'b0;
      mode_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (take) begin
      cnt_q <= cnt_nx;
      ovf_q <= (cnt_nx == MAXC) & ~in_last;
      if (first) begin
        acc_q  <= c;
        mode_q <= mode;
      end else if (mode_q) begin
        acc_q <= acc_q | c;
      end else begin
        acc_q <= acc_q & c;
      end
    end
  end

`ifdef CONSTRAINT_FAIL_IDX_EN
  logic [CW-1:0] fidx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fidx_q <= '0;
    end else if (take) begin
      if (first)
        fidx_q <= c ? '0 : CW'(1);
      else if (fidx_q == '0 && !c)
        fidx_q <= cnt_nx;
    end
  end

  assign out_fail_idx = fidx_q;
`endif

  assign out_sat   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_constraint_stream_eval.sv
// Directed bench for constraint_stream_eval with default parameters.
// Checks reset, aggregation, overflow, hold behaviour and async reset.
module tb_constraint_stream_eval;

  localparam int WIDTH = 10;
  localparam int CW    = 5;

  logic             clk = 0;
  logic             rst_n = 0;
  logic             in_valid = 0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 0;
  logic             mode = 0;
  logic             out_valid;
  logic             out_ready = 0;
  logic             out_sat;
  logic [CW-1:0]    out_count;
  logic             out_ovf;
`ifdef CONSTRAINT_FAIL_IDX_EN
  logic [CW-1:0]    out_fail_idx;
`endif

  int n_run = 0;
  int n_fail = 0;

  constraint_stream_eval dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat),
    .out_count (out_count),
`ifdef CONSTRAINT_FAIL_IDX_EN
    .out_fail_idx (out_fail_idx),
`endif
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [WIDTH-1:0] d, input logic l,
                      input logic m);
    in_valid = 1;
    in_data  = d;
    in_last  = l;
    mode     = m;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic take_result(input string tag);
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    check({tag, "_vld_drop"}, int'(out_valid), 0);
    check({tag, "_rdy_back"}, int'(in_ready), 1);
  endtask

  initial begin
    #3;
    check("rst_rdy", int'(in_ready), 1);
    check("rst_vld", int'(out_valid), 0);
    check("rst_sat", int'(out_sat), 0);
    check("rst_cnt", int'(out_count), 0);
    check("rst_ovf", int'(out_ovf), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;

    // ALL mode, both beats pass
    beat(10'h300, 0, 0);
    check("a_vld_mid", int'(out_valid), 0);
    beat(10'h200, 1, 0);
    check("a_vld", int'(out_valid), 1);
    check("a_rdy", int'(in_ready), 0);
    check("a_sat", int'(out_sat), 1);
    check("a_cnt", int'(out_count), 2);
    check("a_ovf", int'(out_ovf), 0);
`ifdef CONSTRAINT_FAIL_IDX_EN
    check("a_fidx", int'(out_fail_idx), 0);
`endif
    take_result("a");

    // ALL mode, second beat fails
    beat(10'h300, 0, 0);
    beat(10'h001, 0, 0);
    beat(10'h100, 1, 0);
    check("b_sat", int'(out_sat), 0);
    check("b_cnt", int'(out_count), 3);
`ifdef CONSTRAINT_FAIL_IDX_EN
    check("b_fidx", int'(out_fail_idx), 2);
`endif
    take_result("b");

    // ANY mode latched; mode toggled mid-frame must be ignored
    beat(10'h005, 0, 1);
    beat(10'h3FF, 0, 0);
    beat(10'h100, 1, 0);
    check("c_sat", int'(out_sat), 1);
    check("c_cnt", int'(out_count), 3);
    take_result("c");

    // ANY mode, none pass
    beat(10'h0C1, 0, 1);
    beat(10'h002, 1, 1);
    check("d_sat", int'(out_sat), 0);
    take_result("d");

    // overflow at MAX_BEATS
    for (int i = 0; i < 15; i++) beat(10'h000, 0, 0);
    check("e_vld_15", int'(out_valid), 0);
    check("e_cnt_15", int'(out_count), 15);
    beat(10'h000, 0, 0);
    check("e_vld", int'(out_valid), 1);
    check("e_cnt", int'(out_count), 16);
    check("e_ovf", int'(out_ovf), 1);
    check("e_sat", int'(out_sat), 1);
    take_result("e");
    beat(10'h000, 1, 0);
    check("e17_cnt", int'(out_count), 1);
    check("e17_ovf", int'(out_ovf), 0);
    take_result("e17");

    // in_last on beat 16 is a normal close
    for (int i = 0; i < 15; i++) beat(10'h000, 0, 0);
    beat(10'h000, 1, 0);
    check("f_cnt", int'(out_count), 16);
    check("f_ovf", int'(out_ovf), 0);
    take_result("f");

    // hold with back-pressure, offered beats ignored
    beat(10'h004, 0, 0);
    beat(10'h000, 1, 0);
    in_valid = 1;
    in_data  = 10'h000;
    in_last  = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("h_rdy", int'(in_ready), 0);
      check("h_vld", int'(out_valid), 1);
      check("h_sat", int'(out_sat), 0);
      check("h_cnt", int'(out_count), 2);
    end
    in_valid = 0;
    in_last  = 0;
    take_result("h");

    // async reset mid-frame
    beat(10'h000, 0, 0);
    beat(10'h000, 0, 0);
    beat(10'h000, 0, 0);
    #2;
    rst_n = 0;
    #1;
    check("r_rdy", int'(in_ready), 1);
    check("r_vld", int'(out_valid), 0);
    check("r_cnt", int'(out_count), 0);
    check("r_sat", int'(out_sat), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    beat(10'h000, 1, 0);
    check("r2_vld", int'(out_valid), 1);
    check("r2_cnt", int'(out_count), 1);
    check("r2_sat", int'(out_sat), 1);
    take_result("r2");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
